// File: rtl/fleet_config.sv
// Fleet-setup controller: captures per-player ship counts (popcount of sw) on confirm presses.
// Optional macro FLEET_CFG_EQUAL_EN: one commit fills every player slot and locks at once.
module fleet_config #(
  parameter int SW_WIDTH    = 5,
  parameter int NUM_PLAYERS = 2,
  parameter int MIN_SHIPS   = 1,
  parameter int MAX_SHIPS   = 5,
  localparam int CW = $clog2(SW_WIDTH + 1),
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SW_WIDTH-1:0]       sw,
  input  logic                      confirm,
  input  logic                      clear_cfg,
  output logic [CW-1:0]             preview_count,
  output logic [PW-1:0]             player_idx,
  output logic [NUM_PLAYERS*CW-1:0] ship_counts,
  output logic                      count_err,
  output logic                      cfg_valid
);

  typedef enum logic {
    SETUP  = 1'b0,
    LOCKED = 1'b1
  } state_t;

`ifndef FLEET_CFG_EQUAL_EN
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PLAYERS - 1);
`endif

  state_t                    state_q, state_d;
  logic                      conf_q;
  logic                      rise;
  logic                      in_range;
  logic                      commit;
  logic [CW-1:0]             pop;
  logic [PW-1:0]             idx_d;
  logic [NUM_PLAYERS*CW-1:0] counts_d;
  logic                      err_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < SW_WIDTH; i++) pop = pop + CW'(sw[i]);
  end

  // The commit uses the previously registered popcount, so sw must settle a cycle before the press.
  assign rise     = confirm & ~conf_q;
  assign in_range = (int'(preview_count) >= MIN_SHIPS) && (int'(preview_count) <= MAX_SHIPS);
  assign commit   = (state_q == SETUP) && rise && in_range && !clear_cfg;

  // cfg_valid is the state itself, so it doubles as the FSM state observation point.
  assign cfg_valid = (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SETUP;
      conf_q        <= 1'b0;
      preview_count <= '0;
      player_idx    <= '0;
      ship_counts   <= '0;
      count_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      conf_q        <= confirm;
      preview_count <= pop;
      player_idx    <= idx_d;
      ship_counts   <= counts_d;
      count_err     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETUP: begin
`ifdef FLEET_CFG_EQUAL_EN
        if (commit) state_d = LOCKED;
`else
        if (commit && (player_idx == LAST_IDX)) state_d = LOCKED;
`endif
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = SETUP;
    endcase
    if (clear_cfg) state_d = SETUP;
  end

  always_comb begin
    idx_d    = player_idx;
    counts_d = ship_counts;
    err_d    = 1'b0;
    if (clear_cfg) begin
      idx_d    = '0;
      counts_d = '0;
    end else if (state_q == SETUP && rise) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else begin
`ifdef FLEET_CFG_EQUAL_EN
        for (int p = 0; p < NUM_PLAYERS; p++) counts_d[p*CW +: CW] = preview_count;
`else
        for (int p = 0; p < NUM_PLAYERS; p++)
          if (PW'(p) == player_idx) counts_d[p*CW +: CW] = preview_count;
        if (player_idx != LAST_IDX) idx_d = player_idx + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fleet_config.sv
// Directed bench for fleet_config (default parameters); table of per-cycle vectors plus
// hand-written sequences for held confirm and asynchronous reset. Honours FLEET_CFG_EQUAL_EN.
module tb_fleet_config;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sw;
  logic       confirm;
  logic       clear_cfg;
  logic [2:0] preview_count;
  logic [0:0] player_idx;
  logic [5:0] ship_counts;
  logic       count_err;
  logic       cfg_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fleet_config dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .confirm       (confirm),
    .clear_cfg     (clear_cfg),
    .preview_count (preview_count),
    .player_idx    (player_idx),
    .ship_counts   (ship_counts),
    .count_err     (count_err),
    .cfg_valid     (cfg_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sw;
    logic       conf;
    logic       clr;
    logic [2:0] p;
    logic       idx;
    logic [5:0] cnt;
    logic       err;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] s, input logic c, input logic cl,
                              input logic [2:0] p, input logic idx, input logic [5:0] cnt,
                              input logic err, input logic vld);
    vec_t v;
    v.sw = s; v.conf = c; v.clr = cl; v.p = p; v.idx = idx; v.cnt = cnt; v.err = err; v.vld = vld;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] p, input logic idx,
                           input logic [5:0] cnt, input logic err, input logic vld);
    check({tag, " preview_count"}, 32'(preview_count), 32'(p));
    check({tag, " player_idx"},    32'(player_idx),    32'(idx));
    check({tag, " ship_counts"},   32'(ship_counts),   32'(cnt));
    check({tag, " count_err"},     32'(count_err),     32'(err));
    check({tag, " cfg_valid"},     32'(cfg_valid),     32'(vld));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step(input logic [4:0] s, input logic c, input logic cl);
    sw = s; confirm = c; clear_cfg = cl;
    @(posedge clk);
    #1;
  endtask

`ifdef FLEET_CFG_EQUAL_EN
  localparam logic       HOLD_IDX = 1'b0;
  localparam logic [5:0] HOLD_CNT = 6'b010_010;
  localparam logic       HOLD_VLD = 1'b1;
`else
  localparam logic       HOLD_IDX = 1'b1;
  localparam logic [5:0] HOLD_CNT = 6'b000_010;
  localparam logic       HOLD_VLD = 1'b0;
`endif

  initial begin
`ifdef FLEET_CFG_EQUAL_EN
    vecs.push_back(mk(5'b01100, 0, 0, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b01100, 0, 0, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0, 3'd0, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00000, 1, 0, 3'd0, 0, 6'b000_000, 1, 0));
    vecs.push_back(mk(5'b01100, 0, 0, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b01100, 1, 0, 3'd2, 0, 6'b010_010, 0, 1));
    vecs.push_back(mk(5'b01100, 0, 0, 3'd2, 0, 6'b010_010, 0, 1));
    vecs.push_back(mk(5'b11111, 0, 0, 3'd5, 0, 6'b010_010, 0, 1));
    vecs.push_back(mk(5'b11111, 1, 0, 3'd5, 0, 6'b010_010, 0, 1));
    vecs.push_back(mk(5'b11111, 0, 1, 3'd5, 0, 6'b000_000, 0, 0));
`else
    vecs.push_back(mk(5'b10110, 0, 0, 3'd3, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b10110, 0, 0, 3'd3, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00111, 0, 0, 3'd3, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00111, 1, 0, 3'd3, 1, 6'b000_011, 0, 0));
    vecs.push_back(mk(5'b00111, 0, 0, 3'd3, 1, 6'b000_011, 0, 0));
    vecs.push_back(mk(5'b11111, 0, 0, 3'd5, 1, 6'b000_011, 0, 0));
    vecs.push_back(mk(5'b11111, 1, 0, 3'd5, 1, 6'b101_011, 0, 1));
    vecs.push_back(mk(5'b11111, 0, 0, 3'd5, 1, 6'b101_011, 0, 1));
    vecs.push_back(mk(5'b00000, 1, 0, 3'd0, 1, 6'b101_011, 0, 1));
    vecs.push_back(mk(5'b00000, 0, 0, 3'd0, 1, 6'b101_011, 0, 1));
    vecs.push_back(mk(5'b00000, 0, 1, 3'd0, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00000, 0, 0, 3'd0, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00000, 1, 0, 3'd0, 0, 6'b000_000, 1, 0));
    vecs.push_back(mk(5'b00000, 0, 0, 3'd0, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00011, 0, 0, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00011, 1, 0, 3'd2, 1, 6'b000_010, 0, 0));
    vecs.push_back(mk(5'b00011, 0, 0, 3'd2, 1, 6'b000_010, 0, 0));
    vecs.push_back(mk(5'b00011, 1, 1, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00011, 1, 0, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00011, 0, 0, 3'd2, 0, 6'b000_000, 0, 0));
    vecs.push_back(mk(5'b00011, 1, 0, 3'd2, 1, 6'b000_010, 0, 0));
`endif

    // Reset phase: outputs stay at reset values even with switches set.
    rst = 1'b1; sw = 5'b10110; confirm = 1'b0; clear_cfg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 1'b0, 6'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].sw, vecs[i].conf, vecs[i].clr);
      check_all($sformatf("row%0d", i), vecs[i].p, vecs[i].idx, vecs[i].cnt, vecs[i].err, vecs[i].vld);
    end

    // Confirm held high for 10 cycles commits exactly once.
    step(5'b00011, 1'b0, 1'b1);
    step(5'b00011, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(5'b00011, 1'b1, 1'b0);
      check_all($sformatf("hold%0d", k), 3'd2, HOLD_IDX, HOLD_CNT, 1'b0, HOLD_VLD);
    end
    step(5'b00011, 1'b0, 1'b0);

    // Asynchronous reset takes effect before the next clock edge.
    rst = 1'b1;
    #2;
    check_all("async_rst", 3'd0, 1'b0, 6'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(5'b00011, 1'b0, 1'b0);
    check_all("post_rst", 3'd2, 1'b0, 6'b0, 1'b0, 1'b0);
    step(5'b00011, 1'b1, 1'b0);
    check_all("post_rst_commit", 3'd2, HOLD_IDX, HOLD_CNT, 1'b0, HOLD_VLD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
